// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared constants, entry state and entry layout for the reservation stations
//   FUNC_MUL / FUNC_DIV  legal mul/div function codes
//   rs_state_t           entry lifecycle FREE -> WAIT/READY -> EXEC -> FREE
//   rs_entry_t           payload held by one station entry
package tomasulo_pkg;
    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] FUNC_DIV = 4'b0011;
    localparam int RS_DATA_W = 8;
    localparam int RS_ROB_W  = 3;
    localparam int RS_REG_W  = 4;
    typedef enum logic [1:0] {
        FREE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        EXEC  = 2'd3
    } rs_state_t;
    typedef struct packed {
        logic [3:0]           func;
        logic [RS_REG_W-1:0]  rd;
        logic [RS_ROB_W-1:0]  rob;
        logic [RS_DATA_W-1:0] s1_val;
        logic [RS_ROB_W-1:0]  s1_tag;
        logic                 s1_vld;
        logic [RS_DATA_W-1:0] s2_val;
        logic [RS_ROB_W-1:0]  s2_tag;
        logic                 s2_vld;
    } rs_entry_t;
    function automatic logic is_muldiv(input logic [3:0] f);
        return f == FUNC_MUL || f == FUNC_DIV;
    endfunction
endpackage

// File: rtl/rs_prio_pick.sv
// rs_prio_pick: lowest-index one-hot picker with a valid flag
//   req  in   N  request vector
//   gnt  out  N  one-hot grant of the lowest set request bit
//   any  out  1  at least one request bit is set
module rs_prio_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any
);
    // Two's complement isolates the lowest set bit.
    assign gnt = req & (~req + N'(1));
    assign any = |req;
endmodule

// File: rtl/muldiv_rs.sv
// muldiv_rs: reservation station feeding the non-pipelined mul/div unit
//   clk1, rst_n                 clock, synchronous active-low reset
//   alloc_*                     issue-stage op, accepted on alloc_valid && alloc_ready
//   alloc_err                   pulse when an illegal func was accepted and dropped
//   cdb_valid/tag/data          common data bus snoop
//   ex_b, rs1_data..rs_index    registered one-cycle dispatch to the unit
//   ex_done, done_index         completion from the unit, frees an EXEC entry
//   flush                       discards every entry and the in-flight op
//   occupancy                   number of non-FREE entries
module muldiv_rs
    import tomasulo_pkg::*;
#(
    parameter int N_ENTRIES = 3,
    parameter int DATA_W    = 8,
    parameter int ROB_W     = 3,
    parameter int REG_W     = 4,
    parameter int IDX_W     = 2
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [3:0]        alloc_func,
    input  logic [REG_W-1:0]  alloc_rd,
    input  logic [ROB_W-1:0]  alloc_rob,
    input  logic              alloc_s1_rdy,
    input  logic              alloc_s2_rdy,
    input  logic [DATA_W-1:0] alloc_s1_val,
    input  logic [DATA_W-1:0] alloc_s2_val,
    input  logic [ROB_W-1:0]  alloc_s1_tag,
    input  logic [ROB_W-1:0]  alloc_s2_tag,
    output logic              alloc_err,
    input  logic              cdb_valid,
    input  logic [ROB_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              ex_b,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [3:0]        func,
    output logic [REG_W-1:0]  rd,
    output logic [ROB_W-1:0]  rob_ind,
    output logic [IDX_W-1:0]  rs_index,
    input  logic              ex_done,
    input  logic [IDX_W-1:0]  done_index,
    input  logic              flush,
    output logic [IDX_W:0]    occupancy
);
    rs_state_t             st [N_ENTRIES];
    rs_entry_t             ent [N_ENTRIES];
    rs_entry_t             new_ent;
    logic                  unit_busy;
    logic [N_ENTRIES-1:0]  free_vec, rdy_vec, free_oh, rdy_oh, hit1, hit2;
    logic                  free_any, rdy_any, legal, do_alloc, do_disp, done_hit;

    rs_prio_pick #(.N(N_ENTRIES)) u_free_pick (.req(free_vec), .gnt(free_oh), .any(free_any));
    rs_prio_pick #(.N(N_ENTRIES)) u_rdy_pick  (.req(rdy_vec),  .gnt(rdy_oh),  .any(rdy_any));

    assign alloc_ready = free_any;
    assign legal       = is_muldiv(alloc_func);
    assign do_alloc    = alloc_valid && free_any && legal;
    assign do_disp     = rdy_any && !unit_busy;

    // The incoming op also snoops the CDB so a same-cycle broadcast is never missed.
    always_comb begin
        new_ent        = '0;
        new_ent.func   = alloc_func;
        new_ent.rd     = alloc_rd;
        new_ent.rob    = alloc_rob;
        new_ent.s1_tag = alloc_s1_tag;
        new_ent.s2_tag = alloc_s2_tag;
        new_ent.s1_val = alloc_s1_rdy ? alloc_s1_val : cdb_data;
        new_ent.s2_val = alloc_s2_rdy ? alloc_s2_val : cdb_data;
        new_ent.s1_vld = alloc_s1_rdy || (cdb_valid && cdb_tag == alloc_s1_tag);
        new_ent.s2_vld = alloc_s2_rdy || (cdb_valid && cdb_tag == alloc_s2_tag);
    end

    always_comb begin
        free_vec  = '0;
        rdy_vec   = '0;
        hit1      = '0;
        hit2      = '0;
        occupancy = '0;
        done_hit  = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            free_vec[i] = st[i] == FREE;
            rdy_vec[i]  = st[i] == READY;
            hit1[i]     = st[i] == WAIT && !ent[i].s1_vld && cdb_valid && cdb_tag == ent[i].s1_tag;
            hit2[i]     = st[i] == WAIT && !ent[i].s2_vld && cdb_valid && cdb_tag == ent[i].s2_tag;
            occupancy   = occupancy + (IDX_W+1)'(st[i] != FREE);
            done_hit    = done_hit || (ex_done && st[i] == EXEC && done_index == IDX_W'(i));
        end
    end

    // Snoop, alloc, dispatch and completion each act on entries in a distinct
    // registered state, so at most one of them touches any given entry per cycle.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) st[i] <= FREE;
            unit_busy <= 1'b0;
            ex_b      <= 1'b0;
            alloc_err <= 1'b0;
            rs1_data  <= '0;
            rs2_data  <= '0;
            func      <= '0;
            rd        <= '0;
            rob_ind   <= '0;
            rs_index  <= '0;
        end else if (flush) begin
            for (int i = 0; i < N_ENTRIES; i++) st[i] <= FREE;
            unit_busy <= 1'b0;
            ex_b      <= 1'b0;
            alloc_err <= 1'b0;
        end else begin
            ex_b      <= do_disp;
            alloc_err <= alloc_valid && free_any && !legal;
            if (do_disp)
                unit_busy <= 1'b1;
            else if (done_hit)
                unit_busy <= 1'b0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (hit1[i]) begin
                    ent[i].s1_val <= cdb_data;
                    ent[i].s1_vld <= 1'b1;
                end
                if (hit2[i]) begin
                    ent[i].s2_val <= cdb_data;
                    ent[i].s2_vld <= 1'b1;
                end
                if (st[i] == WAIT && (ent[i].s1_vld || hit1[i]) && (ent[i].s2_vld || hit2[i]))
                    st[i] <= READY;
                if (do_alloc && free_oh[i]) begin
                    ent[i] <= new_ent;
                    st[i]  <= (new_ent.s1_vld && new_ent.s2_vld) ? READY : WAIT;
                end
                if (do_disp && rdy_oh[i]) begin
                    st[i]    <= EXEC;
                    rs1_data <= ent[i].s1_val;
                    rs2_data <= ent[i].s2_val;
                    func     <= ent[i].func;
                    rd       <= ent[i].rd;
                    rob_ind  <= ent[i].rob;
                    rs_index <= IDX_W'(i);
                end
                if (done_hit && done_index == IDX_W'(i))
                    st[i] <= FREE;
            end
        end
    end
endmodule
